// File: rtl/mux_seq_pkg.sv
// Shared definitions for the registered channel multiplexer: select modes,
// legal channel-count range and a constant clog2 helper.
package mux_seq_pkg;

    localparam int N_CH_MIN = 2;
    localparam int N_CH_MAX = 16;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Smallest r with 2**r >= n; usable in parameter and generate expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_seq_ptr.sv
// Modulo-N round-robin pointer with synchronous clear (priority) and advance
// enable; it never holds an index >= N.
module mux_seq_ptr
    import mux_seq_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == LAST) ? '0 : ptr + W'(1);
        end
    end

endmodule

// File: rtl/mux_seq_reg.sv
// Registered N-channel word multiplexer with direct/scan select modes and a
// single-entry valid/ready output stage.
module mux_seq_reg
    import mux_seq_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 1,
    parameter int SEL_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_CH*WIDTH-1:0] d,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  scan_en,
    input  logic                  scan_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      q,
    output logic [SEL_W-1:0]      q_sel,
    output logic                  q_err
);

    localparam int              SW1    = SEL_W + 1;
    localparam logic [SEL_W:0]  N_CH_L = SW1'(N_CH);

    if (SEL_W != clog2(N_CH) || N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_params
        $error("mux_seq_reg: N_CH must be 2..16 and SEL_W must equal clog2(N_CH)");
    end

    mode_e             mode;
    logic [SEL_W-1:0]  scan_ptr;
    logic [SEL_W-1:0]  esel;
    logic              esel_err;
    logic              xfer;
    logic [WIDTH-1:0]  mux_word;

    assign mode     = mode_e'(scan_en);
    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;
    assign esel     = (mode == MODE_SCAN) ? scan_ptr : sel;
    assign esel_err = ({1'b0, esel} >= N_CH_L);

    // Out-of-range selects fall through to zero rather than reading past d.
    always_comb begin
        mux_word = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (esel == SEL_W'(k)) begin
                mux_word = d[k*WIDTH +: WIDTH];
            end
        end
    end

    mux_seq_ptr #(
        .N (N_CH),
        .W (SEL_W)
    ) u_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (xfer && mode == MODE_SCAN),
        .clr   (scan_clr),
        .ptr   (scan_ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q         <= '0;
            q_sel     <= '0;
            q_err     <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            q         <= esel_err ? '0 : mux_word;
            q_sel     <= esel;
            q_err     <= esel_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    // Copy of the accepted input word, used only to check q against its source.
    logic [N_CH*WIDTH-1:0] d_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_hold <= '0;
        end else if (xfer) begin
            d_hold <= d;
        end
    end

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> ($stable(q) && $stable(q_sel) && $stable(q_err)));

    a_err_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        q_err == ({1'b0, q_sel} >= N_CH_L));

    a_ptr_range: assert property (@(posedge clk) disable iff (!rst_n)
        {1'b0, scan_ptr} < N_CH_L);

    for (genvar k = 0; k < N_CH; k++) begin : g_data_chk
        a_data: assert property (@(posedge clk) disable iff (!rst_n)
            (out_valid && !q_err && q_sel == SEL_W'(k)) |-> (q == d_hold[k*WIDTH +: WIDTH]));
    end
`endif

endmodule

// File: tb/tb_mux_seq_reg.sv
// Scoreboard bench driving a 4-channel x 8-bit and a 3-channel x 4-bit
// instance with identical stimulus, checked against a behavioural model.
module tb_mux_seq_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid;
    logic [1:0]  sel;
    logic        scan_en;
    logic        scan_clr;
    logic        out_ready;
    logic [31:0] d;

    logic        in_ready4, out_valid4, q_err4;
    logic [7:0]  q4;
    logic [1:0]  q_sel4;
    logic        in_ready3, out_valid3, q_err3;
    logic [3:0]  q3;
    logic [1:0]  q_sel3;

    always #5 clk = ~clk;

    mux_seq_reg #(.N_CH(4), .WIDTH(8), .SEL_W(2)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .d         (d),
        .sel       (sel),
        .scan_en   (scan_en),
        .scan_clr  (scan_clr),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .q         (q4),
        .q_sel     (q_sel4),
        .q_err     (q_err4)
    );

    mux_seq_reg #(.N_CH(3), .WIDTH(4), .SEL_W(2)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .d         (d[11:0]),
        .sel       (sel),
        .scan_en   (scan_en),
        .scan_clr  (scan_clr),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .q         (q3),
        .q_sel     (q_sel3),
        .q_err     (q_err3)
    );

    typedef struct packed {
        logic [7:0] q;
        logic [1:0] sel;
        logic       err;
    } exp_t;

    exp_t exp4[$];
    exp_t exp3[$];
    int   seen4[$];
    int   seen3[$];
    int   tests = 0;
    int   fails = 0;
    bit   model_valid = 1'b0;
    int   ptr4 = 0;
    int   ptr3 = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkSeq(input string name, input int got[$], input int want[$]);
        checkOutput({name, "_len"}, 32'(got.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < got.size(); i++) begin
            checkOutput($sformatf("%s[%0d]", name, i), 32'(got[i]), 32'(want[i]));
        end
    endtask

    task automatic modelReset();
        model_valid = 1'b0;
        ptr4 = 0;
        ptr3 = 0;
        exp4.delete();
        exp3.delete();
    endtask

    // One clock of stimulus; the model decides acceptance and predicts the result.
    task automatic applyStimulus(input bit iv, input int s, input bit se, input bit sc,
                                 input bit ordy, input logic [31:0] data);
        bit   exp_ready;
        bit   xfer;
        int   e4;
        int   e3;
        exp_t x;
        @(posedge clk);
        #1;
        in_valid  = iv;
        sel       = s[1:0];
        scan_en   = se;
        scan_clr  = sc;
        out_ready = ordy;
        d         = data;
        #1;
        exp_ready = !model_valid || ordy;
        checkOutput("out_valid4", 32'(out_valid4), 32'(model_valid));
        checkOutput("out_valid3", 32'(out_valid3), 32'(model_valid));
        checkOutput("in_ready4", 32'(in_ready4), 32'(exp_ready));
        checkOutput("in_ready3", 32'(in_ready3), 32'(exp_ready));
        xfer = iv && exp_ready;
        if (xfer) begin
            e4 = se ? ptr4 : s;
            e3 = se ? ptr3 : s;
            x.q   = 8'((data >> (8 * e4)) & 32'hFF);
            x.sel = e4[1:0];
            x.err = 1'b0;
            exp4.push_back(x);
            x.q   = (e3 < 3) ? 8'((data >> (4 * e3)) & 32'hF) : 8'h00;
            x.sel = e3[1:0];
            x.err = (e3 >= 3);
            exp3.push_back(x);
        end
        if (xfer) begin
            model_valid = 1'b1;
        end else if (ordy) begin
            model_valid = 1'b0;
        end
        if (sc) begin
            ptr4 = 0;
            ptr3 = 0;
        end else if (xfer && se) begin
            ptr4 = (ptr4 + 1) % 4;
            ptr3 = (ptr3 + 1) % 3;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 32'h0);
        end
    endtask

    // Monitor: a result is consumed when out_valid && out_ready at the coming edge.
    always @(negedge clk) begin
        exp_t x;
        if (rst_n) begin
            if (out_valid4 && out_ready) begin
                if (exp4.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected4: got q=0x%0h, expected no output", q4);
                end else begin
                    x = exp4.pop_front();
                    checkOutput("q4", 32'(q4), 32'(x.q));
                    checkOutput("q_sel4", 32'(q_sel4), 32'(x.sel));
                    checkOutput("q_err4", 32'(q_err4), 32'(x.err));
                end
                seen4.push_back(int'(q_sel4));
            end
            if (out_valid3 && out_ready) begin
                if (exp3.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected3: got q=0x%0h, expected no output", q3);
                end else begin
                    x = exp3.pop_front();
                    checkOutput("q3", 32'(q3), 32'(x.q));
                    checkOutput("q_sel3", 32'(q_sel3), 32'(x.sel));
                    checkOutput("q_err3", 32'(q_err3), 32'(x.err));
                end
                seen3.push_back(int'(q_sel3));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int want[$];
        in_valid  = 1'b0;
        sel       = 2'd0;
        scan_en   = 1'b0;
        scan_clr  = 1'b0;
        out_ready = 1'b0;
        d         = 32'h0;

        #2;
        checkOutput("rst_out_valid4", 32'(out_valid4), 32'd0);
        checkOutput("rst_q4", 32'(q4), 32'd0);
        checkOutput("rst_q_sel4", 32'(q_sel4), 32'd0);
        checkOutput("rst_q_err4", 32'(q_err4), 32'd0);
        checkOutput("rst_in_ready4", 32'(in_ready4), 32'd1);
        checkOutput("rst_out_valid3", 32'(out_valid3), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();

        // Direct select of channel 2, then a three-cycle stall and a drain.
        applyStimulus(1'b1, 2, 1'b0, 1'b0, 1'b1, 32'h44332211);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput("direct_q4", 32'(q4), 32'h33);
            checkOutput("direct_q_sel4", 32'(q_sel4), 32'd2);
            checkOutput("direct_q_err4", 32'(q_err4), 32'd0);
        end
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        idleCycles(1);

        // Scan wrap over five back-to-back transfers.
        seen4.delete();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 0, 1'b1, 1'b0, 1'b1, $urandom);
        end
        idleCycles(2);
        want = '{0, 1, 2, 3, 0};
        checkSeq("scan_wrap", seen4, want);

        // Clear the pointer, then clear again alongside the third transfer.
        applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b1, 32'h0);
        seen4.delete();
        seen3.delete();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 0, 1'b1, (i == 2), 1'b1, $urandom);
        end
        idleCycles(2);
        want = '{0, 1, 2, 0, 1};
        checkSeq("scan_clr4", seen4, want);
        checkSeq("scan_clr3", seen3, want);

        // Select 3 is illegal for the three-channel instance only.
        applyStimulus(1'b1, 3, 1'b0, 1'b0, 1'b1, 32'hFEDCBA98);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("illegal_q3", 32'(q3), 32'd0);
        checkOutput("illegal_q_err3", 32'(q_err3), 32'd1);
        checkOutput("illegal_q_sel3", 32'(q_sel3), 32'd3);
        checkOutput("legal_q4", 32'(q4), 32'hFE);
        idleCycles(2);

        // Scan on three channels wraps after index 2.
        applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b1, 32'h0);
        seen3.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3, 1'b1, 1'b0, 1'b1, $urandom);
        end
        idleCycles(2);
        want = '{0, 1, 2, 0};
        checkSeq("scan3_wrap", seen3, want);

        // Asynchronous reset while a stalled result is pending.
        applyStimulus(1'b1, 0, 1'b1, 1'b0, 1'b0, $urandom);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid4", 32'(out_valid4), 32'd0);
        checkOutput("midrst_q4", 32'(q4), 32'd0);
        checkOutput("midrst_scan_ptr4", 32'(u_dut4.scan_ptr), 32'd0);
        checkOutput("midrst_out_valid3", 32'(out_valid3), 32'd0);
        checkOutput("midrst_scan_ptr3", 32'(u_dut3.scan_ptr), 32'd0);
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic with mode switches, clears and back-pressure.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 3) != 0), $urandom);
        end
        idleCycles(4);
        checkOutput("left4", 32'(exp4.size()), 32'd0);
        checkOutput("left3", 32'(exp3.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
